// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and scoreboard entry type for the pipeline interlock controller.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package pipe_hazard_ctrl_pkg;

    // Operand source selects driven to the ID/EX forwarding muxes.
    localparam logic [1:0] FWD_RF     = 2'b00;  // register file read port
    localparam logic [1:0] FWD_EXALU  = 2'b01;  // ALU result of the instruction in EX
    localparam logic [1:0] FWD_MEMALU = 2'b10;  // ALU result carried in MEM
    localparam logic [1:0] FWD_MEMDAT = 2'b11;  // load data returning in MEM

    // PC source encodings produced by the ID decoder.
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_ILL = 2'b11;

    // One in-flight register write tracked per downstream stage.
    typedef struct packed {
        logic       wreg;   // instruction writes the register file
        logic       m2reg;  // write data comes from memory (load)
        logic [4:0] wn;     // destination register number
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // r0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
        return e.wreg && (e.wn == r) && (r != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// Resolves one source operand against the EX/MEM/WB scoreboard: forward select or stall request.
// Latency: purely combinational, 0 cycles.
// Backpressure: stall_req is the only throttle; the top turns it into a PC hold plus bubble.
module hazard_operand_check
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN       = 1'b1,
    parameter bit RF_WRITE_THROUGH = 1'b1
) (
    input  logic [4:0] reg_num,
    input  logic       use_reg,
    input  sb_entry_t  ex_entry,
    input  sb_entry_t  mem_entry,
    input  sb_entry_t  wb_entry,
    output logic [1:0] fwd,
    output logic       stall_req
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Only the WB destination matters; its load flag has no effect on the decision.
    logic unused_wb_m2reg;
    assign unused_wb_m2reg = wb_entry.m2reg;

    assign ex_hit  = use_reg && sb_match(ex_entry,  reg_num);
    assign mem_hit = use_reg && sb_match(mem_entry, reg_num);
    assign wb_hit  = use_reg && sb_match(wb_entry,  reg_num);

    // Youngest producer wins: EX shadows MEM, MEM shadows WB.
    always_comb begin
        fwd       = FWD_RF;
        stall_req = 1'b0;
        if (FORWARD_EN) begin
            if (ex_hit) begin
                // Load data is not available until MEM, so a load in EX must wait one cycle.
                if (ex_entry.m2reg) begin
                    stall_req = 1'b1;
                end else begin
                    fwd = FWD_EXALU;
                end
            end else if (mem_hit) begin
                fwd = mem_entry.m2reg ? FWD_MEMDAT : FWD_MEMALU;
            end else if (wb_hit && !RF_WRITE_THROUGH) begin
                // No WB bypass exists; without write-through the read would be stale.
                stall_req = 1'b1;
            end
        end else begin
            stall_req = ex_hit || mem_hit || (wb_hit && !RF_WRITE_THROUGH);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock controller: scoreboard of in-flight writes, stall/bubble, branch flush, forwarding.
// Latency: control outputs are combinational from ID inputs and scoreboard (0 cycles); illegal/counters registered.
// Backpressure: a stall holds PC and IF/ID (pc_we=0) and injects a bubble into ID/EX until the hazard clears.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN       = 1'b1,
    parameter bit RF_WRITE_THROUGH = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [4:0]       id_wn,
    input  logic [1:0]       id_pcsource,
    output logic             pc_we,
    output logic             id_bubble,
    output logic             ifid_flush,
    output logic [1:0]       pcsource_q,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Scoreboard: what each downstream stage will write back.
    sb_entry_t ex_q;
    sb_entry_t mem_q;
    sb_entry_t wb_q;
    sb_entry_t ex_d;

    logic [1:0] fwda_raw;
    logic [1:0] fwdb_raw;
    logic       stall_rs;
    logic       stall_rt;

    logic       stall;
    logic       is_ill;
    logic       is_redirect;
    logic       issue;
    logic       flush;

    hazard_operand_check #(
        .FORWARD_EN       (FORWARD_EN),
        .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
    ) u_chk_rs (
        .reg_num   (id_rs),
        .use_reg   (id_use_rs),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .fwd       (fwda_raw),
        .stall_req (stall_rs)
    );

    hazard_operand_check #(
        .FORWARD_EN       (FORWARD_EN),
        .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
    ) u_chk_rt (
        .reg_num   (id_rt),
        .use_reg   (id_use_rt),
        .ex_entry  (ex_q),
        .mem_entry (mem_q),
        .wb_entry  (wb_q),
        .fwd       (fwdb_raw),
        .stall_req (stall_rt)
    );

    assign is_ill      = (id_pcsource == PCSRC_ILL);
    assign is_redirect = (id_pcsource == PCSRC_BR) || (id_pcsource == PCSRC_J);

    // A stall outranks everything except reset; a held branch is only taken once it issues.
    assign stall = !rst && id_valid && (stall_rs || stall_rt);
    assign issue = !rst && id_valid && !stall && !is_ill;
    assign flush = issue && is_redirect;

    // Only an issuing instruction enters EX; stalls, flushed slots and illegal opcodes become bubbles.
    always_comb begin
        ex_d = SB_EMPTY;
        if (issue) begin
            ex_d.wreg  = id_wreg;
            ex_d.m2reg = id_m2reg;
            ex_d.wn    = id_wn;
        end
    end

    // Pipeline control decode, in priority order: reset, empty slot, stall, illegal, normal issue.
    always_comb begin
        pc_we      = 1'b1;
        id_bubble  = 1'b0;
        ifid_flush = 1'b0;
        pcsource_q = PCSRC_SEQ;
        fwda       = FWD_RF;
        fwdb       = FWD_RF;
        if (rst) begin
            pc_we     = 1'b0;
            id_bubble = 1'b1;
        end else if (!id_valid) begin
            id_bubble = 1'b1;
        end else if (stall) begin
            pc_we     = 1'b0;
            id_bubble = 1'b1;
        end else if (is_ill) begin
            // Fetch keeps going sequentially; the bad instruction is dropped and flagged.
            id_bubble = 1'b1;
        end else begin
            fwda = fwda_raw;
            fwdb = fwdb_raw;
            if (flush) begin
                pcsource_q = id_pcsource;
                ifid_flush = 1'b1;
            end
        end
    end

    // Scoreboard shift: EX <- ID decision, MEM <- EX, WB <- MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (id_valid && is_ill) begin
            illegal <= 1'b1;
        end
    end

    // Saturating stall-cycle counter for performance debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    // Saturating IF/ID flush counter for performance debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default, no-forwarding, and no-forwarding/no-write-through builds.
// Latency: expected control outputs are queued at drive time and compared after combinational settle.
// Backpressure: stall expectations are scripted cycle by cycle; every step is a fixed cycle count.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic       id_m2reg;
    logic [4:0] id_wn;
    logic [1:0] id_pcsource;

    // Instance a: defaults (forwarding, write-through, 16-bit counters)
    logic        a_pc_we, a_id_bubble, a_ifid_flush, a_illegal;
    logic [1:0]  a_pcsource_q, a_fwda, a_fwdb;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    // Instance b: no forwarding, write-through
    logic        b_pc_we, b_id_bubble, b_ifid_flush, b_illegal;
    logic [1:0]  b_pcsource_q, b_fwda, b_fwdb;
    logic [15:0] b_stall_cnt, b_flush_cnt;
    // Instance c: no forwarding, no write-through, 8-bit counters for saturation
    logic        c_pc_we, c_id_bubble, c_ifid_flush, c_illegal;
    logic [1:0]  c_pcsource_q, c_fwda, c_fwdb;
    logic [7:0]  c_stall_cnt, c_flush_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       pc_we;
        logic       bubble;
        logic       flush;
        logic [1:0] pcs;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctrl u_dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_wn(id_wn), .id_pcsource(id_pcsource), .pc_we(a_pc_we), .id_bubble(a_id_bubble),
        .ifid_flush(a_ifid_flush), .pcsource_q(a_pcsource_q), .fwda(a_fwda), .fwdb(a_fwdb),
        .illegal(a_illegal), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .RF_WRITE_THROUGH(1'b1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_wn(id_wn), .id_pcsource(id_pcsource), .pc_we(b_pc_we), .id_bubble(b_id_bubble),
        .ifid_flush(b_ifid_flush), .pcsource_q(b_pcsource_q), .fwda(b_fwda), .fwdb(b_fwdb),
        .illegal(b_illegal), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .RF_WRITE_THROUGH(1'b0), .CNT_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_wn(id_wn), .id_pcsource(id_pcsource), .pc_we(c_pc_we), .id_bubble(c_id_bubble),
        .ifid_flush(c_ifid_flush), .pcsource_q(c_pcsource_q), .fwda(c_fwda), .fwdb(c_fwdb),
        .illegal(c_illegal), .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("%s comparison did not hold", tag);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic w, input logic m,
                         input logic [4:0] wn, input logic [1:0] pcs);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_wreg     = w;
        id_m2reg    = m;
        id_wn       = wn;
        id_pcsource = pcs;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00);
    endtask

    task automatic expect_a(input logic pc_we, input logic bub, input logic fl,
                            input logic [1:0] pcs, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.pc_we  = pc_we;
        e.bubble = bub;
        e.flush  = fl;
        e.pcs    = pcs;
        e.fa     = fa;
        e.fb     = fb;
        exp_q.push_back(e);
    endtask

    // Let the combinational outputs settle, then pop the queued expectation and compare.
    task automatic check_a(input string tag);
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".pc_we"},      a_pc_we,      e.pc_we);
            chk({tag, ".id_bubble"},  a_id_bubble,  e.bubble);
            chk({tag, ".ifid_flush"}, a_ifid_flush, e.flush);
            chk({tag, ".pcsource_q"}, a_pcsource_q, e.pcs);
            chk({tag, ".fwda"},       a_fwda,       e.fa);
            chk({tag, ".fwdb"},       a_fwdb,       e.fb);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            nop();
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;

        // Reset is asserted: everything held
        expect_a(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("rst_active");
        chk("rst_illegal", a_illegal, 1'b0);
        chk("rst_stall_cnt", a_stall_cnt, 16'd0);
        chk("rst_flush_cnt", a_flush_cnt, 16'd0);

        // Reset released with an empty ID slot
        rst = 1'b0;
        expect_a(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("release_idle");
        cyc();

        // add r3 ; and r5,r3,r4 ; or r6,r3,r4 -> EX then MEM ALU forwarding
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("add_r3");
        cyc();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
        check_a("fwd_ex_alu");
        cyc();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
        check_a("fwd_mem_alu");
        cyc();
        nop();
        expect_a(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("idle_after_alu");
        chk("alu_no_stalls", a_stall_cnt, 16'd0);
        drain();

        // lw r2 ; addi r6,r2 -> one load-use stall then load-data forward
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("lw_r2");
        cyc();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 2'b00);
        expect_a(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("load_use_stall");
        cyc();
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00);
        check_a("load_use_fwd");
        chk("load_use_stall_cnt", a_stall_cnt, 16'd1);
        cyc();
        drain();

        // lw r2 ; beq r2,r7 -> branch held through the stall, taken once it issues
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("lw_r2_again");
        cyc();
        drive(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'b01);
        expect_a(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("beq_stall");
        cyc();
        expect_a(1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b00);
        check_a("beq_taken");
        chk("beq_flush_cnt_before", a_flush_cnt, 16'd0);
        cyc();
        nop();
        expect_a(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("beq_shadow");
        chk("beq_flush_cnt", a_flush_cnt, 16'd1);
        chk("beq_stall_cnt", a_stall_cnt, 16'd2);
        drain();

        // Writes to r0 never create a dependency
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("lw_r0");
        cyc();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("read_r0");
        cyc();
        drain();

        // Illegal opcode: flagged, dropped, and sticky
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 2'b11);
        expect_a(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("illegal_op");
        chk("illegal_before_edge", a_illegal, 1'b0);
        cyc();
        chk("illegal_set", a_illegal, 1'b1);
        drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("after_illegal_no_fwd");
        cyc();
        chk("illegal_sticky", a_illegal, 1'b1);
        drain();

        // Jump: one flush cycle
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10);
        expect_a(1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00);
        check_a("jump");
        cyc();
        nop();
        chk("jump_flush_cnt", a_flush_cnt, 16'd2);
        chk("illegal_still_set", a_illegal, 1'b1);
        cyc();

        // Reset in the middle of a load-use stall
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("lw_before_rst");
        cyc();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 2'b00);
        expect_a(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("stall_before_rst");
        cyc();
        rst = 1'b1;
        expect_a(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("rst_mid_stall");
        cyc();
        rst = 1'b0;
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("after_rst_no_stall");
        chk("rst_clears_illegal", a_illegal, 1'b0);
        chk("rst_clears_stall_cnt", a_stall_cnt, 16'd0);
        chk("rst_clears_flush_cnt", a_flush_cnt, 16'd0);
        cyc();
        drain();
        chk("b_stall_cnt_start", b_stall_cnt, 16'd0);
        chk("c_stall_cnt_start", c_stall_cnt, 8'd0);

        // add r3 ; consumer of r3 held -> b stalls 2 cycles, c stalls 3, a forwards
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("nofwd_producer");
        cyc();
        drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 2'b00);
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
        check_a("nofwd_c1_a");
        chk("nofwd_c1_b_pc_we", b_pc_we, 1'b0);
        chk("nofwd_c1_b_bubble", b_id_bubble, 1'b1);
        chk("nofwd_c1_c_pc_we", c_pc_we, 1'b0);
        cyc();
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
        check_a("nofwd_c2_a");
        chk("nofwd_c2_b_pc_we", b_pc_we, 1'b0);
        chk("nofwd_c2_c_pc_we", c_pc_we, 1'b0);
        cyc();
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("nofwd_c3_a");
        chk("nofwd_c3_b_pc_we", b_pc_we, 1'b1);
        chk("nofwd_c3_b_fwda", b_fwda, 2'b00);
        chk("nofwd_c3_c_pc_we", c_pc_we, 1'b0);
        cyc();
        expect_a(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
        check_a("nofwd_c4_a");
        chk("nofwd_c4_c_pc_we", c_pc_we, 1'b1);
        cyc();
        nop();
        chk("nofwd_b_stall_cnt", b_stall_cnt, 16'd2);
        chk("nofwd_c_stall_cnt", c_stall_cnt, 8'd3);
        chk("nofwd_a_stall_cnt", a_stall_cnt, 16'd0);
        drain();

        // Self-dependent add r3,r3 for 400 cycles: c saturates its 8-bit stall counter
        for (int i = 0; i < 400; i++) begin
            drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 2'b00);
            cyc();
        end
        chk("sat_c_stall_cnt", c_stall_cnt, 8'hFF);
        chk("sat_a_no_stall", a_stall_cnt, 16'd0);

        // Back-to-back jumps for 300 cycles: c saturates flush, a counts exactly
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10);
            cyc();
        end
        chk("sat_c_flush_cnt", c_flush_cnt, 8'hFF);
        chk("a_flush_cnt_300", a_flush_cnt, 16'd300);
        chk("sat_c_stall_hold", c_stall_cnt, 8'hFF);
        nop();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
